// File: rtl/clk_iq_pkg.sv
// Shared types and the quadrature phase-order helper for the I/Q clock monitor.
package clk_iq_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} iq_mon_state_e;

  typedef enum logic [2:0] {
    FLT_NONE  = 3'd0,
    FLT_SKIP  = 3'd1,
    FLT_REV   = 3'd2,
    FLT_STALL = 3'd3,
    FLT_COMP  = 3'd4
  } iq_fault_e;

  // {I,Q} forward order: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] iq_fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   iq_fwd_next = 2'b10;
      2'b10:   iq_fwd_next = 2'b11;
      2'b11:   iq_fwd_next = 2'b01;
      default: iq_fwd_next = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/clk_iq_sync.sv
// Multi-flop synchronizer bringing the asynchronous 4-phase clock bus into the cki domain.
module clk_iq_sync
  import clk_iq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       cki,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] stage_q [SYNC_STAGES];

  always_ff @(posedge cki) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_iq_mon.sv
// Receive-side monitor for the {~Q,~I,Q,I} divided clock bus: quadrature order,
// complementarity, I period, lock/direction status and sticky fault reporting.
module clk_iq_mon
  import clk_iq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STEPS  = 8,
  parameter int STALL_MAX   = 64,
  parameter int PW          = 8
) (
  input  logic          cki,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    ck_iq,
  input  logic          clr_fault,
  output logic          locked,
  output logic          fault,
  output logic [2:0]    fault_code,
  output logic          iq_dir,
  output logic [PW-1:0] period,
  output logic          period_vld
);

  localparam int GW = $clog2(LOCK_STEPS + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [GW-1:0] GOOD_LIM  = GW'(LOCK_STEPS - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX - 1);
  localparam logic [SW-1:0] STALL_SAT = SW'(STALL_MAX);

  logic [3:0]    synced;
  logic [1:0]    s, s_prev;
  logic          step, skip, fwd, bwd, i_rise, good_step;
  logic          comp_bad, comp_bad_p1, comp_err, rev_err, stall_err, any_err;
  iq_fault_e     err_code;
  iq_mon_state_e state;
  logic [GW-1:0] good_cnt;
  logic [SW-1:0] stall_cnt;
  logic [PW-1:0] per_cnt;
  logic          dir_vld, first_rise;

  clk_iq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .cki (cki),
    .rst (rst),
    .d   (ck_iq),
    .q   (synced)
  );

  assign s         = {synced[0], synced[1]};
  assign step      = (s != s_prev);
  assign skip      = (s == ~s_prev);
  assign fwd       = step && (s == iq_fwd_next(s_prev));
  assign bwd       = step && (s_prev == iq_fwd_next(s));
  assign i_rise    = (fwd && s_prev == 2'b00) || (bwd && s_prev == 2'b01);
  assign comp_bad  = (synced[2] != ~synced[0]) || (synced[3] != ~synced[1]);
  // One mismatching sample is edge skew between the true and complement wires
  assign comp_err  = comp_bad && comp_bad_p1;
  assign rev_err   = dir_vld && ((iq_dir && fwd) || (!iq_dir && bwd));
  // Flags on the sample that completes STALL_MAX step-free samples; a step never stalls
  assign stall_err = !step && (stall_cnt >= STALL_LIM);

  always_comb begin
    err_code = FLT_NONE;
    if (comp_err)       err_code = FLT_COMP;
    else if (skip)      err_code = FLT_SKIP;
    else if (rev_err)   err_code = FLT_REV;
    else if (stall_err) err_code = FLT_STALL;
  end

  assign any_err   = (err_code != FLT_NONE);
  assign good_step = (fwd || bwd) && !any_err;

  // Stage p1: previous sample, complement history, stall timer
  always_ff @(posedge cki) begin
    if (rst) begin
      s_prev      <= '0;
      comp_bad_p1 <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      s_prev      <= s;
      comp_bad_p1 <= comp_bad;
      if (state == IDLE || step)    stall_cnt <= '0;
      else if (stall_cnt != STALL_SAT) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge cki) begin
    if (rst) begin
      state      <= IDLE;
      locked     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      iq_dir     <= 1'b0;
      dir_vld    <= 1'b0;
      good_cnt   <= '0;
      first_rise <= 1'b1;
      per_cnt    <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      locked     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      iq_dir     <= 1'b0;
      dir_vld    <= 1'b0;
      good_cnt   <= '0;
      first_rise <= 1'b1;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (state != IDLE) begin
        if (i_rise) begin
          per_cnt <= PW'(1);
          if (first_rise) begin
            first_rise <= 1'b0;
          end else begin
            period     <= per_cnt;
            period_vld <= 1'b1;
          end
        end else if (per_cnt != '1) begin
          per_cnt <= per_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          state      <= ACQ;
          good_cnt   <= '0;
          dir_vld    <= 1'b0;
          first_rise <= 1'b1;
        end
        ACQ: begin
          if (any_err) begin
            good_cnt <= '0;
          end else if (good_step) begin
            if (!dir_vld) begin
              dir_vld <= 1'b1;
              iq_dir  <= bwd;
            end
            if (good_cnt == GOOD_LIM) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (any_err) begin
            state      <= FAULT;
            locked     <= 1'b0;
            fault      <= 1'b1;
            fault_code <= err_code;
          end
        end
        default: begin
          // Sticky until cleared; clearing wins over a same-cycle error
          if (clr_fault) begin
            state      <= ACQ;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            good_cnt   <= '0;
            dir_vld    <= 1'b0;
            first_rise <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
